arrhythmia_frame_loader: RTL and testbench

ARRHYTHMIA_FRAME_LOADER -- requirements
Module: arrhythmia_frame_loader

---
 rtl/arrhythmia_frame_loader.sv | 174 +++++++++++++++++
 tb/tb_arrhythmia_frame_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arrhythmia_frame_loader.sv
// ---------------------------------------------------------------------------
// arrhythmia_frame_loader
//
// Collects a frame of NUM_FEAT feature bytes from a valid/ready byte stream
// into slot registers that drive an external combinational classifier. Once
// a well-formed frame is complete, it waits EVAL_LAT cycles for the classifier
// to settle, then captures the class code and offers it downstream on a
// valid/ready result port. Malformed frames are dropped and flagged with a
// one-cycle error pulse.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   s_valid    : feature byte valid
//   s_data     : feature byte
//   s_last     : final byte of a frame
//   s_ready    : block accepts a byte (LOAD state only)
//   feat_bus   : classifier feature vector, slot k at [k*FEAT_W +: FEAT_W]
//                (slot order X6, X13, X169, X236, X251, X260, X278)
//   cls_in     : classifier class result (combinational from feat_bus)
//   m_valid    : result valid
//   m_class    : captured class code
//   m_ready    : downstream accepts the result
//   frame_err  : one-cycle pulse after a malformed frame is dropped
//   frame_cnt  : saturating count of delivered results
// ---------------------------------------------------------------------------
module arrhythmia_frame_loader #(
  parameter int NUM_FEAT = 7,
  parameter int FEAT_W   = 8,
  parameter int CLS_W    = 5,
  parameter int EVAL_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  input  logic [FEAT_W-1:0]          s_data,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
  input  logic [CLS_W-1:0]           cls_in,
  output logic                       m_valid,
  output logic [CLS_W-1:0]           m_class,
  input  logic                       m_ready,
  output logic                       frame_err,
  output logic [15:0]                frame_cnt
);

  localparam int IDX_W  = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int WAIT_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_EVAL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 m_valid_q, m_valid_d;
  logic [CLS_W-1:0]     m_class_q, m_class_d;
  logic                 frame_err_q, frame_err_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [FEAT_W-1:0]    slot_q [NUM_FEAT];
  logic [FEAT_W-1:0]    slot_d [NUM_FEAT];
  // Clears in reset and sets on the first edge afterwards, so s_ready stays
  // low while rst_n is held even though the state register sits in LOAD.
  logic                 armed_q;

  logic accept;
  logic at_last_slot;

  assign s_ready      = armed_q && (state_q == ST_LOAD);
  assign accept       = s_valid && s_ready;
  assign at_last_slot = (idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    m_valid_d   = m_valid_q;
    m_class_d   = m_class_q;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    slot_d      = slot_q;

    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          // Bytes of a frame that later turns out malformed still land in
          // their slots; only a clean frame ever reaches EVAL.
          slot_d[idx_q] = s_data;
          if (at_last_slot && s_last) begin
            idx_d   = '0;
            wait_d  = WAIT_W'(EVAL_LAT);
            state_d = ST_EVAL;
          end else if (at_last_slot || s_last) begin
            idx_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_EVAL: begin
        // Counter runs down to zero, then cls_in is sampled on the following
        // edge: EVAL_LAT+1 cycles after the last byte was accepted.
        if (wait_q == '0) begin
          m_class_d = cls_in;
          m_valid_d = 1'b1;
          state_d   = ST_HOLD;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end

      ST_HOLD: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          if (frame_cnt_q != 16'hFFFF) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
          state_d = ST_LOAD;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      wait_q      <= '0;
      m_valid_q   <= 1'b0;
      m_class_q   <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
      armed_q     <= 1'b0;
      for (int k = 0; k < NUM_FEAT; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      m_valid_q   <= m_valid_d;
      m_class_q   <= m_class_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
      armed_q     <= 1'b1;
      for (int k = 0; k < NUM_FEAT; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_FEAT; gi++) begin : g_feat_pack
      assign feat_bus[gi*FEAT_W +: FEAT_W] = slot_q[gi];
    end
  endgenerate

  assign m_valid   = m_valid_q;
  assign m_class   = m_class_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_arrhythmia_frame_loader.sv
module tb_arrhythmia_frame_loader;

  localparam int NF = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_valid4;
  logic [7:0]  s_data;
  logic        s_last;
  logic [4:0]  cls_in;
  logic        m_ready, m_ready4;

  logic        s_ready, s_ready4;
  logic [55:0] feat_bus, feat_bus4;
  logic        m_valid, m_valid4;
  logic [4:0]  m_class, m_class4;
  logic        frame_err, frame_err4;
  logic [15:0] frame_cnt, frame_cnt4;

  always #5 clk = ~clk;

  arrhythmia_frame_loader #(.NUM_FEAT(7), .FEAT_W(8), .CLS_W(5), .EVAL_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .feat_bus(feat_bus), .cls_in(cls_in), .m_valid(m_valid),
    .m_class(m_class), .m_ready(m_ready), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  arrhythmia_frame_loader #(.NUM_FEAT(7), .FEAT_W(8), .CLS_W(5), .EVAL_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid4), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready4), .feat_bus(feat_bus4), .cls_in(cls_in), .m_valid(m_valid4),
    .m_class(m_class4), .m_ready(m_ready4), .frame_err(frame_err4), .frame_cnt(frame_cnt4)
  );

  // Reference model state: what each slot should hold and the result count.
  logic [7:0]  mslot [NF];
  logic [15:0] mcnt;
  logic [7:0]  byte_q [$];
  int          n_cmp = 0;
  int          n_fail = 0;

  typedef struct {
    int         len;
    bit         last;
    logic [4:0] cls;
    int         hold;
    bit         pub;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_bus();
    logic [63:0] v = '0;
    for (int k = 0; k < NF; k++) v[k*8 +: 8] = mslot[k];
    return v;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Offer one byte to the EVAL_LAT=1 instance; returns at the negedge just
  // after the accepting edge.
  task automatic push(input logic [7:0] d, input logic l);
    int guard = 0;
    @(negedge clk);
    while (!s_ready && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) check("push_ready_timeout", 64'd0, 64'd1);
    s_valid = 1'b1; s_data = d; s_last = l;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'($urandom);
  endtask

  task automatic run_frame(input int len, input bit last_f, input bit rnd,
                           input logic [4:0] cls_fix, input int hold, input bit exp_pub);
    logic [7:0] b;
    logic [4:0] cls_last;
    int cnt;
    for (int k = 0; k < len; k++) begin
      b = (byte_q.size() > 0) ? byte_q.pop_front() : 8'($urandom);
      push(b, (k == len - 1) ? last_f : 1'b0);
      mslot[k] = b;
      if (k == len - 1) begin
        cls_last = rnd ? 5'($urandom) : cls_fix;
        cls_in = cls_last;
        if (rnd) m_ready = 1'($urandom);
      end
    end
    check("feat_bus_after_last", {8'h0, feat_bus}, exp_bus());
    if (!exp_pub) begin
      check("frame_err_pulse", {63'd0, frame_err}, 64'd1);
      @(negedge clk);
      check("frame_err_one_cycle", {63'd0, frame_err}, 64'd0);
      for (int i = 0; i < 3; i++) begin
        check("no_m_valid_on_drop", {63'd0, m_valid}, 64'd0);
        @(negedge clk);
      end
      check("cnt_unchanged_on_drop", {48'd0, frame_cnt}, {48'd0, mcnt});
      m_ready = 1'b0;
    end else begin
      check("no_err_on_good", {63'd0, frame_err}, 64'd0);
      cnt = 0;
      while (!m_valid && cnt < 40) begin
        @(negedge clk);
        cnt++;
        if (!m_valid && rnd) begin
          cls_last = 5'($urandom);
          cls_in = cls_last;
          m_ready = 1'($urandom);
        end
      end
      m_ready = 1'b0;
      check("result_latency", 64'(cnt), 64'd2);
      check("m_class_capture", {59'd0, m_class}, {59'd0, cls_last});
      check("s_ready_low_in_hold", {63'd0, s_ready}, 64'd0);
      for (int h = 0; h < hold; h++) begin
        s_valid = 1'($urandom); s_data = 8'($urandom); s_last = 1'($urandom);
        cls_in = rnd ? 5'($urandom) : 5'd2;
        @(negedge clk);
        check("hold_m_valid", {63'd0, m_valid}, 64'd1);
        check("hold_m_class", {59'd0, m_class}, {59'd0, cls_last});
        check("hold_s_ready", {63'd0, s_ready}, 64'd0);
        check("hold_feat_bus", {8'h0, feat_bus}, exp_bus());
      end
      s_valid = 1'b0; s_last = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      mcnt = sat_inc(mcnt);
      check("m_valid_drop", {63'd0, m_valid}, 64'd0);
      check("frame_cnt", {48'd0, frame_cnt}, {48'd0, mcnt});
      check("s_ready_after_hs", {63'd0, s_ready}, 64'd1);
    end
    $display("frame len=%0d last=%0b published=%0b class=%0d cnt=%0h",
             len, last_f, exp_pub, m_class, frame_cnt);
  endtask

  initial begin
    logic [7:0]  b;
    logic [4:0]  target;
    int          cnt;
    int          len;
    bit          lf;

    tbl[0] = '{len: 7, last: 1'b1, cls: 5'd25, hold: 3,  pub: 1'b1};
    tbl[1] = '{len: 4, last: 1'b1, cls: 5'd0,  hold: 0,  pub: 1'b0};
    tbl[2] = '{len: 7, last: 1'b1, cls: 5'd25, hold: 20, pub: 1'b1};
    tbl[3] = '{len: 7, last: 1'b0, cls: 5'd0,  hold: 0,  pub: 1'b0};
    tbl[4] = '{len: 1, last: 1'b1, cls: 5'd0,  hold: 0,  pub: 1'b0};
    tbl[5] = '{len: 7, last: 1'b1, cls: 5'd31, hold: 1,  pub: 1'b1};
    tbl[6] = '{len: 6, last: 1'b1, cls: 5'd0,  hold: 0,  pub: 1'b0};
    tbl[7] = '{len: 7, last: 1'b1, cls: 5'd0,  hold: 0,  pub: 1'b1};

    rst_n = 1'b0; s_valid = 1'b0; s_valid4 = 1'b0; s_data = 8'd0; s_last = 1'b0;
    cls_in = 5'd0; m_ready = 1'b0; m_ready4 = 1'b0;
    mcnt = 16'd0;
    for (int k = 0; k < NF; k++) mslot[k] = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_feat_bus", {8'h0, feat_bus}, 64'd0);
    check("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
    check("rst_m_class", {59'd0, m_class}, 64'd0);
    check("rst_frame_err", {63'd0, frame_err}, 64'd0);
    rst_n = 1'b1;
    check("s_ready_before_first_edge", {63'd0, s_ready}, 64'd0);
    @(negedge clk);
    check("s_ready_after_first_edge", {63'd0, s_ready}, 64'd1);

    // EVAL_LAT=4 instance: latency and single-edge sampling of cls_in
    for (int k = 0; k < NF; k++) begin
      @(negedge clk);
      cnt = 0;
      while (!s_ready4 && cnt < 20) begin @(negedge clk); cnt++; end
      s_valid4 = 1'b1; s_data = 8'($urandom); s_last = (k == NF - 1);
      @(negedge clk);
      s_valid4 = 1'b0; s_last = 1'b0;
    end
    target = 5'($urandom);
    cnt = 0;
    while (!m_valid4 && cnt < 40) begin
      cls_in = (cnt == 4) ? target : (target ^ 5'($urandom_range(1, 31)));
      @(negedge clk);
      cnt++;
    end
    check("lat4_latency", 64'(cnt), 64'd5);
    check("lat4_m_class", {59'd0, m_class4}, {59'd0, target});
    m_ready4 = 1'b1;
    @(negedge clk);
    m_ready4 = 1'b0;
    check("lat4_frame_cnt", {48'd0, frame_cnt4}, 64'd1);
    $display("lat4 frame class=%0d cnt=%0h", m_class4, frame_cnt4);

    // Table-driven frames; entry 0 uses the fixed byte sequence 10..60,20
    byte_q = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd20};
    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i].len, tbl[i].last, 1'b0, tbl[i].cls, tbl[i].hold, tbl[i].pub);
      if (i == 0) check("req035_slot6", {56'd0, feat_bus[55:48]}, 64'd20);
    end

    // Reset after the 3rd byte of a frame
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      push(b, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    mcnt = 16'd0;
    for (int k = 0; k < NF; k++) mslot[k] = 8'd0;
    check("midrst_feat_bus", {8'h0, feat_bus}, 64'd0);
    check("midrst_s_ready", {63'd0, s_ready}, 64'd0);
    check("midrst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
    check("midrst_m_valid", {63'd0, m_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_err", {63'd0, frame_err}, 64'd0);
    end
    run_frame(7, 1'b1, 1'b0, 5'd9, 1, 1'b1);

    // Randomized frames against the model
    for (int i = 0; i < 30; i++) begin
      len = $urandom_range(1, 7);
      lf  = (len < 7) ? 1'b1 : ($urandom_range(0, 3) != 0);
      run_frame(len, lf, 1'b1, 5'd0, $urandom_range(0, 3), (len == 7) && lf);
    end

    // Saturation: preset the counter next to its ceiling
    @(negedge clk);
    dut.frame_cnt_q = 16'hFFFE;
    mcnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      run_frame(7, 1'b1, 1'b1, 5'd0, 0, 1'b1);
    end
    check("saturated_cnt", {48'd0, frame_cnt}, 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
